iir_deemph: RTL and testbench
=============================

Name: iir_deemph

Overview:
- First-order fixed-point de-emphasis IIR filter for the FM stereo path.
- Sits directly downstream of the L/R sum stage: it pops summed 32-bit samples from the input FIFO, filters them, and pushes the results to the output FIFO feeding the gain stage.
- Uses one shared multiplier, time-multiplexed across three taps.

Parameters:
- DATA_WIDTH, 32, sample width (signed two's complement).
- BITS, 10, quantization shift (Q-format fraction bits).
- X0, 178, quantized coefficient on x[n].
- X1, 178, quantized coefficient on x[n-1].
- Y1, 666, quantized feedback coefficient on y[n-1].

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_rd_en  out  1  pop request to input FIFO.
- in_empty  in  1  input FIFO empty.
- in_dout  in  DATA_WIDTH  input sample x[n], signed; valid in the same cycle in_rd_en is asserted (FWFT).
- out_wr_en  out  1  push request to output FIFO.
- out_full  in  1  output FIFO full.
- out_din  out  DATA_WIDTH  filtered sample y[n], signed.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=S_READ; x_prev=0, y_prev=0, acc=0.
  - in_rd_en=0, out_wr_en=0, out_din=0.
- Filter function:
  - y[n] = dq(X0*x[n]) + dq(X1*x[n-1]) + dq(Y1*y[n-1]).
  - Products are full 2*DATA_WIDTH signed.
  - dq(p) = p / 2^BITS, truncating toward zero: if p<0, add 2^BITS-1 before the arithmetic right shift. This matches the C golden model.
  - Each dq result is truncated to DATA_WIDTH.
  - Sum is DATA_WIDTH wrap-around; no saturation.
- FSM (one multiply per cycle):
  - S_READ: if !in_empty, assert in_rd_en for 1 cycle, latch x=in_dout, acc=0, go S_M0. Otherwise hold with in_rd_en=0.
  - S_M0: acc+=dq(X0*x) -> S_M1.
  - S_M1: acc+=dq(X1*x_prev) -> S_M2.
  - S_M2: acc+=dq(Y1*y_prev) -> S_WRITE.
  - S_WRITE: if !out_full, out_wr_en=1, out_din=acc, y_prev=acc, x_prev=x, go S_READ. Otherwise hold with out_wr_en=0 and all state unchanged.
- Outputs are combinational from registered state; out_din=0 whenever out_wr_en=0.
- Latency and throughput:
  - Pop to push is 4 cycles when unblocked.
  - Maximum throughput is 1 sample per 5 cycles.
- Boundaries:
  - Empty input: stall in S_READ indefinitely; no spurious pops.
  - Full output: stall in S_WRITE; history is not updated until the push commits, so no sample is lost or duplicated.
  - in_empty and out_full together: only the state-relevant one matters.
  - Reset mid-sample: the in-flight sample is discarded and history is cleared. The already-popped input is not replayed.
  - Default/illegal state: go to S_READ and clear acc.
- in_rd_en and out_wr_en are never asserted in the same cycle.

Decomposition:
- Shared package (e.g. fm_radio_pkg):
  - DATA_WIDTH and BITS constants.
  - De-emphasis coefficient constants X0/X1/Y1.
  - dequantize function (truncate toward zero).
  - State enum typedef.
- No sub-module required. The multiplier plus dequantize is a single inline expression.

Test Plan:
- Impulse: x = 1024, then 0, 0. Expect y = 178, 293, 190 (293 = 178 + dq(666*178) = 178 + 115).
- Negative impulse: x = -1024, then 0. Expect y = -178, -293. This checks truncation toward zero, not floor (floor would give -294).
- DC step: 60 samples of x = 1000 from reset. Expect y[0] = 173, y[1] = 458, monotonically rising, reaching and holding exactly 987.
- Backpressure: hold out_full=1 for 20 cycles while S_WRITE is pending, during the impulse test. Expect out_wr_en=0 throughout, no in_rd_en, and the identical sequence 178, 293, 190 after release.
- Starvation: toggle in_empty randomly across 200 cycles. Expect in_rd_en only when !in_empty in S_READ, and output count equal to input count.
- Reset mid-op: assert reset in S_M1 after x = 1024, then release and feed x = 1024, 0. Expect y = 178, 293 (history cleared), with all outputs 0 during reset.

Source files
------------

// File: rtl/iir_deemph_pkg.sv
// Shared constants, state encoding and dequantize helper for the FM de-emphasis filter.
// Coefficients are Q.BITS fixed point.
package iir_deemph_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BITS       = 10;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] X0 = 32'sd178;
    localparam logic signed [DATA_WIDTH-1:0] X1 = 32'sd178;
    localparam logic signed [DATA_WIDTH-1:0] Y1 = 32'sd666;

    localparam logic signed [PROD_WIDTH-1:0] DQ_BIAS = (64'sd1 <<< BITS) - 64'sd1;

    typedef enum logic [2:0] {
        S_READ  = 3'd0,
        S_M0    = 3'd1,
        S_M1    = 3'd2,
        S_M2    = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // Divide by 2^BITS rounding toward zero, matching the C golden model, then keep the low word.
    function automatic logic signed [DATA_WIDTH-1:0] dequantize(input logic signed [PROD_WIDTH-1:0] p);
        logic signed [PROD_WIDTH-1:0] biased;
        logic signed [PROD_WIDTH-1:0] shifted;
        biased  = p[PROD_WIDTH-1] ? (p + DQ_BIAS) : p;
        shifted = biased >>> BITS;
        return shifted[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/iir_deemph.sv
// First-order de-emphasis IIR: y[n] = dq(X0*x[n]) + dq(X1*x[n-1]) + dq(Y1*y[n-1]).
// A single multiplier is shared across the three taps, one tap per cycle.
module iir_deemph
    import iir_deemph_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    output logic                         in_rd_en,
    input  logic                         in_empty,
    input  logic signed [DATA_WIDTH-1:0] in_dout,
    output logic                         out_wr_en,
    input  logic                         out_full,
    output logic signed [DATA_WIDTH-1:0] out_din
);

    state_t state;
    state_t state_next;

    logic signed [DATA_WIDTH-1:0] x_cur;
    logic signed [DATA_WIDTH-1:0] x_prev;
    logic signed [DATA_WIDTH-1:0] y_prev;
    logic signed [DATA_WIDTH-1:0] acc;

    logic signed [DATA_WIDTH-1:0] coef;
    logic signed [DATA_WIDTH-1:0] operand;
    logic signed [PROD_WIDTH-1:0] coef_ext;
    logic signed [PROD_WIDTH-1:0] operand_ext;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [DATA_WIDTH-1:0] term;

    // Tap select for the shared multiplier
    always_comb begin
        coef    = X0;
        operand = x_cur;
        case (state)
            S_M1: begin
                coef    = X1;
                operand = x_prev;
            end
            S_M2: begin
                coef    = Y1;
                operand = y_prev;
            end
            default: ;
        endcase
        coef_ext    = {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef};
        operand_ext = {{DATA_WIDTH{operand[DATA_WIDTH-1]}}, operand};
        product     = coef_ext * operand_ext;
        term        = dequantize(product);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_READ;
        end else begin
            state <= state_next;
        end
    end

    // Pop is also gated by reset so nothing is consumed while the filter is held
    always_comb begin
        state_next = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        out_din    = '0;
        case (state)
            S_READ: begin
                if (!in_empty && reset) begin
                    in_rd_en   = 1'b1;
                    state_next = S_M0;
                end
            end
            S_M0:    state_next = S_M1;
            S_M1:    state_next = S_M2;
            S_M2:    state_next = S_WRITE;
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en  = 1'b1;
                    out_din    = acc;
                    state_next = S_READ;
                end
            end
            default: state_next = S_READ;
        endcase
    end

    // History only advances when the push commits, so a stalled write loses nothing
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_cur  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            acc    <= '0;
        end else begin
            case (state)
                S_READ: begin
                    if (in_rd_en) begin
                        x_cur <= in_dout;
                        acc   <= '0;
                    end
                end
                S_M0, S_M1, S_M2: acc <= acc + term;
                S_WRITE: begin
                    if (out_wr_en) begin
                        y_prev <= acc;
                        x_prev <= x_cur;
                    end
                end
                default: acc <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_deemph.sv
// Self-checking bench for iir_deemph: FWFT source, output sink, arithmetic reference model
// and literal expectations for impulse, step, backpressure, starvation and mid-op reset.
module tb_iir_deemph;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_rd_en;
    logic               in_empty;
    logic signed [31:0] in_dout;
    logic               out_wr_en;
    logic               out_full;
    logic signed [31:0] out_din;

    int     src_q[$];
    int     exp_q[$];
    int     out_log[$];
    int     errors = 0;
    int     checks = 0;
    int     n_in   = 0;
    int     n_out  = 0;
    bit     starve = 1'b0;
    longint model_x_prev = 0;
    longint model_y_prev = 0;

    iir_deemph dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: integer division truncates toward zero; int cast wraps to 32 bits.
    function automatic longint model_dq(input longint p);
        return p / 1024;
    endfunction

    function automatic int model_step(input int x);
        int y;
        y = int'(model_dq(178 * longint'(x))) + int'(model_dq(178 * model_x_prev))
          + int'(model_dq(666 * model_y_prev));
        model_x_prev = longint'(x);
        model_y_prev = longint'(y);
        return y;
    endfunction

    function automatic logic signed [63:0] get_out(input int i);
        if (i < out_log.size()) return 64'(out_log[i]);
        return 'x;
    endfunction

    task automatic drive_inputs();
        in_empty = starve || (src_q.size() == 0);
        in_dout  = (src_q.size() != 0) ? src_q[0] : 0;
    endtask

    task automatic applyStimulus(input int x);
        src_q.push_back(x);
        drive_inputs();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_outputs(input int n, input int budget, input string name);
        int c = 0;
        while (out_log.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        checkOutput({name, "_count"}, 64'(out_log.size()), 64'(n));
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        starve   = 1'b0;
        out_full = 1'b0;
        src_q.delete();
        exp_q.delete();
        out_log.delete();
        model_x_prev = 0;
        model_y_prev = 0;
        n_in  = 0;
        n_out = 0;
        drive_inputs();
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    // FWFT source: the head leaves the queue on the edge where the DUT popped it
    initial begin : source
        bit take;
        forever begin
            @(negedge clock);
            take = in_rd_en;
            @(posedge clock);
            #1;
            if (take && src_q.size() > 0) begin
                src_q.delete(0);
                n_in++;
            end
            drive_inputs();
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                checkOutput("reset_rd_en", 64'(in_rd_en), 0);
                checkOutput("reset_wr_en", 64'(out_wr_en), 0);
                checkOutput("reset_out_din", out_din, 0);
            end else begin
                checkOutput("rd_wr_exclusive", 64'(in_rd_en && out_wr_en), 0);
                if (in_rd_en) begin
                    checkOutput("rd_when_empty", 64'(in_empty), 0);
                    exp_q.push_back(model_step(in_dout));
                end
                if (out_wr_en) begin
                    checkOutput("wr_when_full", 64'(out_full), 0);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_push", 1, 0);
                    end else begin
                        checkOutput("model_y", out_din, 64'(exp_q.pop_front()));
                    end
                    out_log.push_back(out_din);
                    n_out++;
                end else begin
                    checkOutput("idle_out_din", out_din, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        reset    = 1'b0;
        out_full = 1'b0;
        drive_inputs();

        $display("[TB] impulse");
        do_reset();
        applyStimulus(1024);
        applyStimulus(0);
        applyStimulus(0);
        wait_outputs(3, 60, "impulse");
        checkOutput("impulse_y0", get_out(0), 178);
        checkOutput("impulse_y1", get_out(1), 293);
        checkOutput("impulse_y2", get_out(2), 190);

        $display("[TB] negative impulse");
        do_reset();
        applyStimulus(-1024);
        applyStimulus(0);
        wait_outputs(2, 60, "neg_impulse");
        checkOutput("neg_impulse_y0", get_out(0), -178);
        checkOutput("neg_impulse_y1", get_out(1), -293);

        $display("[TB] dc step");
        do_reset();
        for (int i = 0; i < 60; i++) applyStimulus(1000);
        wait_outputs(60, 500, "dc");
        checkOutput("dc_y0", get_out(0), 173);
        checkOutput("dc_y1", get_out(1), 458);
        begin
            bit mono = 1'b1;
            for (int i = 1; i < out_log.size(); i++)
                if (out_log[i] < out_log[i-1]) mono = 1'b0;
            checkOutput("dc_monotonic", 64'(mono), 1);
        end
        checkOutput("dc_y45", get_out(45), 987);
        checkOutput("dc_y59", get_out(59), 987);

        $display("[TB] backpressure");
        do_reset();
        out_full = 1'b1;
        applyStimulus(1024);
        applyStimulus(0);
        applyStimulus(0);
        tick(20);
        checkOutput("bp_pops_held", 64'(n_in), 1);
        checkOutput("bp_no_push", 64'(out_log.size()), 0);
        out_full = 1'b0;
        wait_outputs(3, 60, "bp");
        checkOutput("bp_y0", get_out(0), 178);
        checkOutput("bp_y1", get_out(1), 293);
        checkOutput("bp_y2", get_out(2), 190);

        $display("[TB] starvation");
        do_reset();
        for (int i = 0; i < 12; i++) applyStimulus(int'($urandom_range(0, 4000)) - 2000);
        for (int i = 0; i < 200; i++) begin
            starve = 1'($urandom_range(0, 1));
            drive_inputs();
            tick(1);
        end
        starve = 1'b0;
        drive_inputs();
        wait_outputs(12, 200, "starve");
        checkOutput("starve_inputs", 64'(n_in), 12);
        checkOutput("starve_in_eq_out", 64'(n_out), 64'(n_in));

        $display("[TB] reset mid-op");
        do_reset();
        applyStimulus(1024);
        begin
            int c = 0;
            while (c < 20) begin
                @(negedge clock);
                if (in_rd_en) break;
                c++;
            end
            checkOutput("midrst_pop_seen", 64'(c < 20), 1);
        end
        @(posedge clock);
        #1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        out_log.delete();
        model_x_prev = 0;
        model_y_prev = 0;
        applyStimulus(1024);
        applyStimulus(0);
        #1;
        checkOutput("midrst_rd_en", 64'(in_rd_en), 0);
        checkOutput("midrst_wr_en", 64'(out_wr_en), 0);
        checkOutput("midrst_out_din", out_din, 0);
        tick(3);
        reset = 1'b1;
        wait_outputs(2, 60, "midrst");
        checkOutput("midrst_y0", get_out(0), 178);
        checkOutput("midrst_y1", get_out(1), 293);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
